// File: rtl/alu_pkg.sv
// Shared definitions for the board ALU and its operand loader: widths, opcodes
// and the loader state encoding.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 4;
    localparam int unsigned ALU_OP_W   = 6;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 6'h20;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 6'h22;
    localparam logic [ALU_OP_W-1:0] OP_AND = 6'h24;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 6'h25;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 6'h26;
    localparam logic [ALU_OP_W-1:0] OP_SRA = 6'h03;
    localparam logic [ALU_OP_W-1:0] OP_SRL = 6'h02;
    localparam logic [ALU_OP_W-1:0] OP_NOR = 6'h27;

    // Encoding doubles as the state_led pattern.
    typedef enum logic [1:0] {
        StLoadA  = 2'b00,
        StLoadB  = 2'b01,
        StLoadOp = 2'b10,
        StDone   = 2'b11
    } load_state_e;

    function automatic logic op_supported(input logic [ALU_OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-FF synchronizer, optional debounce
// (ALU_LOADER_DEBOUNCE_EN) and a one-cycle pulse on the rising stable level.
module btn_conditioner
`ifdef ALU_LOADER_DEBOUNCE_EN
#(
    parameter int unsigned DEB_CNT = 1000000,
    parameter int unsigned CNT_W   = 20
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_prev  <= w_stable;
        end
    end

`ifdef ALU_LOADER_DEBOUNCE_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    // Any return to the stable level restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEB_CNT - 1)) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_stable = r_stable;
`else
    assign w_stable = r_sync2;
`endif

    assign pulse = w_stable & ~r_prev;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures A, B and opcode from switches over three button presses and holds them
// for the ALU. Debounce enabled by defining ALU_LOADER_DEBOUNCE_EN.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = ALU_DATA_W,
    parameter int unsigned OP_W    = ALU_OP_W,
    parameter int unsigned DEB_CNT = 1000000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   sw,
    input  logic              btn_load,
    input  logic              btn_clr,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [OP_W-1:0]   op_out,
    output logic              valid,
    output logic              op_err,
    output logic [1:0]        state_led
);

    if ((64'd1 << CNT_W) <= 64'(DEB_CNT)) begin : g_cnt_w_check
        $error("CNT_W too narrow to count to DEB_CNT");
    end

    logic w_load_p;
    logic w_clr_p;

    btn_conditioner
`ifdef ALU_LOADER_DEBOUNCE_EN
    #(
        .DEB_CNT(DEB_CNT),
        .CNT_W  (CNT_W)
    )
`endif
    u_load_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_load),
        .pulse  (w_load_p)
    );

    btn_conditioner
`ifdef ALU_LOADER_DEBOUNCE_EN
    #(
        .DEB_CNT(DEB_CNT),
        .CNT_W  (CNT_W)
    )
`endif
    u_clr_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_clr),
        .pulse  (w_clr_p)
    );

    load_state_e       r_state, w_state_d;
    logic [DATA_W-1:0] r_a, w_a_d;
    logic [DATA_W-1:0] r_b, w_b_d;
    logic [OP_W-1:0]   r_op, w_op_d;
    logic              r_valid;
    logic              r_op_err;

    always_comb begin
        w_state_d = r_state;
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_op_d    = r_op;
        // Clear has priority over a coincident load.
        if (w_clr_p) begin
            w_state_d = StLoadA;
            w_a_d     = '0;
            w_b_d     = '0;
            w_op_d    = '0;
        end else if (w_load_p) begin
            unique case (r_state)
                StLoadA: begin
                    w_a_d     = sw[DATA_W-1:0];
                    w_state_d = StLoadB;
                end
                StLoadB: begin
                    w_b_d     = sw[DATA_W-1:0];
                    w_state_d = StLoadOp;
                end
                StLoadOp: begin
                    w_op_d    = sw;
                    w_state_d = StDone;
                end
                StDone: begin
                    w_state_d = StLoadA;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StLoadA;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_valid  <= 1'b0;
            r_op_err <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_op     <= w_op_d;
            r_valid  <= (w_state_d == StDone);
            r_op_err <= (w_state_d == StDone) && !op_supported(w_op_d);
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign op_out    = r_op;
    assign valid     = r_valid;
    assign op_err    = r_op_err;
    assign state_led = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader; debounce scenario runs only when
// ALU_LOADER_DEBOUNCE_EN is defined.
module tb_alu_operand_loader;

`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int PRESS = 16;
    localparam int LAT   = 11;
`else
    localparam int PRESS = 4;
    localparam int LAT   = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] sw;
    logic       btn_load;
    logic       btn_clr;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [5:0] op_out;
    logic       valid;
    logic       op_err;
    logic [1:0] state_led;

    alu_operand_loader #(
        .DATA_W (4),
        .OP_W   (6),
        .DEB_CNT(8),
        .CNT_W  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_load (btn_load),
        .btn_clr  (btn_clr),
        .a_out    (a_out),
        .b_out    (b_out),
        .op_out   (op_out),
        .valid    (valid),
        .op_err   (op_err),
        .state_led(state_led)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  m_a;
    logic [3:0]  m_b;
    logic [5:0]  m_op;
    logic [1:0]  m_st;
    logic [17:0] exp_q[$];
    logic [17:0] exp_v;

    function automatic logic supp(input logic [5:0] op);
        logic [5:0] tbl [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
        for (int i = 0; i < 8; i++) if (tbl[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [17:0] obs();
        return {a_out, b_out, op_out, valid, op_err, state_led};
    endfunction

    function automatic logic [17:0] model_snap();
        logic done = (m_st == 2'b11);
        return {m_a, m_b, m_op, done, done && !supp(m_op), m_st};
    endfunction

    function automatic void model_reset();
        m_a = '0; m_b = '0; m_op = '0; m_st = 2'b00;
    endfunction

    // Drive one press (load, clear or both), let it settle, and queue the expectation.
    task automatic apply(input logic ld, input logic cl, input logic [5:0] s);
        @(negedge clk);
        sw = s; btn_load = ld; btn_clr = cl;
        repeat (PRESS) @(negedge clk);
        btn_load = 1'b0; btn_clr = 1'b0;
        repeat (PRESS) @(negedge clk);
        if (cl) begin
            model_reset();
        end else if (ld) begin
            case (m_st)
                2'b00: begin m_a = s[3:0]; m_st = 2'b01; end
                2'b01: begin m_b = s[3:0]; m_st = 2'b10; end
                2'b10: begin m_op = s;     m_st = 2'b11; end
                default: m_st = 2'b00;
            endcase
        end
        exp_q.push_back(model_snap());
    endtask

    task automatic test_reset();
        model_reset();
        exp_q.push_back(model_snap());
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL reset: got %h want %h", obs(), exp_v);
        end
    endtask

    task automatic test_sequence();
        logic [5:0] vals [3] = '{6'h05, 6'h03, 6'h20};
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, vals[i]);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL sequence step %0d: got %h want %h", i, obs(), exp_v);
            end
        end
    endtask

    task automatic test_op_err();
        logic [5:0] ops [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27,
                                  6'h3F, 6'h00, 6'h21, 6'h01};
        apply(1'b1, 1'b0, 6'h00);
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, 1'b0, 6'(i + 1));
            apply(1'b1, 1'b0, 6'(14 - i));
            exp_q.delete();
            apply(1'b1, 1'b0, ops[i]);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL op_err op=%h: got %h want %h", ops[i], obs(), exp_v);
            end
            apply(1'b1, 1'b0, 6'h3C);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL done_exit op=%h: got %h want %h", ops[i], obs(), exp_v);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_clear();
        logic [1:0] ld [4] = '{2'b01, 2'b10, 2'b01, 2'b11};
        logic [5:0] sv [4] = '{6'h0A, 6'h2F, 6'h03, 6'h09};
        for (int i = 0; i < 4; i++) begin
            apply(ld[i][0], ld[i][1], sv[i]);
            if (i == 2) begin
                apply(1'b1, 1'b0, 6'h06);
                exp_q.delete();
                exp_q.push_back(model_snap());
                exp_q.delete();
                continue;
            end
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL clear step %0d: got %h want %h", i, obs(), exp_v);
            end
        end
    endtask

    task automatic test_hold();
        apply(1'b0, 1'b1, 6'h00);
        exp_q.delete();
        @(negedge clk);
        sw = 6'h07; btn_load = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i >= LAT + 4) sw = 6'($urandom);
        end
        btn_load = 1'b0;
        repeat (PRESS) @(negedge clk);
        m_a = 4'h7; m_st = 2'b01;
        exp_q.push_back(model_snap());
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL hold: got %h want %h", obs(), exp_v);
        end
    endtask

    task automatic test_latency();
        logic [1:0] st_before;
        apply(1'b0, 1'b1, 6'h00);
        exp_q.delete();
        st_before = m_st;
        @(negedge clk);
        sw = 6'h0B; btn_load = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        n_vec++;
        if (state_led !== st_before) begin
            n_err++;
            $display("FAIL latency_early: got %b want %b", state_led, st_before);
        end
        @(negedge clk);
        n_vec++;
        if (state_led !== 2'b01 || a_out !== 4'hB) begin
            n_err++;
            $display("FAIL latency_edge: got %b/%h want 01/b", state_led, a_out);
        end
        repeat (PRESS) @(negedge clk);
        btn_load = 1'b0;
        repeat (PRESS) @(negedge clk);
        m_a = 4'hB; m_st = 2'b01;
    endtask

`ifdef ALU_LOADER_DEBOUNCE_EN
    task automatic test_debounce();
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            btn_load = 1'b1; sw = 6'h0E;
            repeat (3) @(negedge clk);
            btn_load = 1'b0;
            repeat (5) @(negedge clk);
        end
        repeat (15) @(negedge clk);
        exp_q.push_back(model_snap());
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL glitch: got %h want %h", obs(), exp_v);
        end
        apply(1'b1, 1'b0, 6'h0D);
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL debounced_press: got %h want %h", obs(), exp_v);
        end
    endtask
`endif

    task automatic test_async_reset();
        apply(1'b0, 1'b1, 6'h00);
        apply(1'b1, 1'b0, 6'h09);
        apply(1'b1, 1'b0, 6'h04);
        apply(1'b1, 1'b0, 6'h26);
        for (int i = 0; i < 3; i++) void'(exp_q.pop_front());
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL pre_reset_done: got %h want %h", obs(), exp_v);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        exp_q.push_back(model_snap());
        #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL async_reset: got %h want %h", obs(), exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; sw = '0; btn_load = 1'b0; btn_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_sequence();
        test_op_err();
        test_clear();
        test_hold();
        test_latency();
`ifdef ALU_LOADER_DEBOUNCE_EN
        test_debounce();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
